// File: rtl/instr_register_exec.sv
// Instruction register file with a background executor (1-cycle ALU, 32-step restoring divider).
// Latency: read 1 cycle; ADD/SUB/MULT/PASS writeback 1 cycle after load, DIV/MOD 33 cycles (1 if divisor is 0).
// Backpressure: a load arriving while the executor is busy is dropped and flagged with a load_err pulse.
module instr_register_exec #(
    parameter int ADDR_W = 5,
    parameter int OP_W   = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load_en,
    input  logic [3:0]              opcode,
    input  logic [OP_W-1:0]         operand_a,
    input  logic [OP_W-1:0]         operand_b,
    input  logic [ADDR_W-1:0]       write_pointer,
    input  logic [ADDR_W-1:0]       read_pointer,
    output logic [4+4*OP_W-1:0]     instruction_word,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       done_addr,
    output logic                    load_err,
    output logic                    div_by_zero
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int RES_W = 2*OP_W;
    localparam int CNT_W = $clog2(OP_W);

    localparam logic [3:0] OPC_ZERO  = 4'd0;
    localparam logic [3:0] OPC_PASSA = 4'd1;
    localparam logic [3:0] OPC_PASSB = 4'd2;
    localparam logic [3:0] OPC_ADD   = 4'd3;
    localparam logic [3:0] OPC_SUB   = 4'd4;
    localparam logic [3:0] OPC_MULT  = 4'd5;
    localparam logic [3:0] OPC_DIV   = 4'd6;
    localparam logic [3:0] OPC_MOD   = 4'd7;

    typedef struct packed {
        logic [3:0]       opc;
        logic [OP_W-1:0]  op_a;
        logic [OP_W-1:0]  op_b;
        logic [RES_W-1:0] result;
    } instruction_t;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_WB} state_t;

    state_t               state_q, state_d;
    instruction_t         mem_q [DEPTH];
    logic [DEPTH-1:0]     vld_q;
    instruction_t         rd_q;
    logic                 rd_vld_q;
    logic [3:0]           opc_q;
    logic [OP_W-1:0]      a_q, b_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [OP_W-1:0]      dvd_q, dvs_q, rem_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 dbz_q;
    logic                 done_q, load_err_q, dbz_out_q;
    logic [ADDR_W-1:0]    done_addr_q;

    logic                 load_acc, wb_en;
    logic [OP_W:0]        rem_sh;
    logic [OP_W+1:0]      rem_sub;
    logic [OP_W-1:0]      rem_nx, dvd_nx;
    logic [RES_W-1:0]     a64, b64, q64, r64, exec_res, div_res, wb_result;
    logic [OP_W-1:0]      a_abs, b_abs;
    logic                 is_div_op;

    assign is_div_op = (opcode == OPC_DIV) || (opcode == OPC_MOD);
    assign a_abs     = operand_a[OP_W-1] ? (OP_W'(0) - operand_a) : operand_a;
    assign b_abs     = operand_b[OP_W-1] ? (OP_W'(0) - operand_b) : operand_b;

    // Next-state: loads only in IDLE, divide-by-zero bypasses the iteration straight to writeback
    always_comb begin
        state_d  = state_q;
        load_acc = 1'b0;
        wb_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_en) begin
                    load_acc = 1'b1;
                    if (!is_div_op)             state_d = S_EXEC;
                    else if (operand_b == '0)   state_d = S_WB;
                    else                        state_d = S_DIV;
                end
            end
            S_EXEC: begin
                wb_en   = 1'b1;
                state_d = S_IDLE;
            end
            S_DIV: begin
                if (cnt_q == CNT_W'(OP_W-1)) state_d = S_WB;
            end
            S_WB: begin
                wb_en   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One restoring-divide step on magnitudes; quotient bits shift into the dividend register
    always_comb begin
        rem_sh  = {rem_q, dvd_q[OP_W-1]};
        rem_sub = {1'b0, rem_sh} - {2'b00, dvs_q};
        if (!rem_sub[OP_W+1]) begin
            rem_nx = rem_sub[OP_W-1:0];
            dvd_nx = {dvd_q[OP_W-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[OP_W-1:0];
            dvd_nx = {dvd_q[OP_W-2:0], 1'b0};
        end
    end

    // Result selection: single-cycle ALU on sign-extended operands, or sign-fixed divider output
    always_comb begin
        a64 = {{OP_W{a_q[OP_W-1]}}, a_q};
        b64 = {{OP_W{b_q[OP_W-1]}}, b_q};
        q64 = {{OP_W{1'b0}}, dvd_q};
        r64 = {{OP_W{1'b0}}, rem_q};
        case (opc_q)
            OPC_ZERO:  exec_res = '0;
            OPC_PASSA: exec_res = a64;
            OPC_PASSB: exec_res = b64;
            OPC_ADD:   exec_res = a64 + b64;
            OPC_SUB:   exec_res = a64 - b64;
            OPC_MULT:  exec_res = a64 * b64;
            default:   exec_res = '0;
        endcase
        if (dbz_q)
            div_res = '0;
        else if (opc_q == OPC_MOD)
            div_res = a_q[OP_W-1] ? (RES_W'(0) - r64) : r64;
        else
            div_res = (a_q[OP_W-1] ^ b_q[OP_W-1]) ? (RES_W'(0) - q64) : q64;
        wb_result = (state_q == S_WB) ? div_res : exec_res;
    end

    // FSM state, executor operand latches and divider iteration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            opc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            addr_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_acc) begin
                opc_q  <= opcode;
                a_q    <= operand_a;
                b_q    <= operand_b;
                addr_q <= write_pointer;
                dvd_q  <= a_abs;
                dvs_q  <= b_abs;
                rem_q  <= '0;
                cnt_q  <= '0;
                dbz_q  <= is_div_op && (operand_b == '0);
            end else if (state_q == S_DIV) begin
                dvd_q  <= dvd_nx;
                rem_q  <= rem_nx;
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

    // Register file: load writes the instruction with a cleared result, writeback fills the result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            vld_q <= '0;
        end else begin
            if (load_acc) begin
                mem_q[write_pointer] <= {opcode, operand_a, operand_b, {RES_W{1'b0}}};
                vld_q[write_pointer] <= 1'b0;
            end
            if (wb_en) begin
                mem_q[addr_q].result <= wb_result;
                vld_q[addr_q]        <= 1'b1;
            end
        end
    end

    // Registered read port and status pulses; reads see pre-edge contents on collisions
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q        <= '0;
            rd_vld_q    <= 1'b0;
            done_q      <= 1'b0;
            done_addr_q <= '0;
            load_err_q  <= 1'b0;
            dbz_out_q   <= 1'b0;
        end else begin
            rd_q        <= mem_q[read_pointer];
            rd_vld_q    <= vld_q[read_pointer];
            done_q      <= wb_en;
            load_err_q  <= load_en && (state_q != S_IDLE);
            dbz_out_q   <= wb_en && dbz_q;
            if (wb_en) done_addr_q <= addr_q;
        end
    end

    assign instruction_word = rd_q;
    assign rd_valid         = rd_vld_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign done_addr        = done_addr_q;
    assign load_err         = load_err_q;
    assign div_by_zero      = dbz_out_q;
endmodule

// File: tb/tb_instr_register_exec.sv
// Directed bench for instr_register_exec: reset, ALU ops, divider, collisions, reset abort.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Each scenario task compares against hand-computed values and counts failures.
module tb_instr_register_exec;
    logic         clk = 1'b0;
    logic         reset_n;
    logic         load_en;
    logic [3:0]   opcode;
    logic [31:0]  operand_a, operand_b;
    logic [4:0]   write_pointer, read_pointer;
    logic [131:0] instruction_word;
    logic         rd_valid, busy, done, load_err, div_by_zero;
    logic [4:0]   done_addr;

    int checks   = 0;
    int failures = 0;

    instr_register_exec #(.ADDR_W(5), .OP_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .load_en(load_en), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .write_pointer(write_pointer), .read_pointer(read_pointer),
        .instruction_word(instruction_word), .rd_valid(rd_valid), .busy(busy),
        .done(done), .done_addr(done_addr), .load_err(load_err), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a load for exactly one edge (edge N); returns 1 unit after edge N
    task automatic do_load(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] wp);
        load_en = 1'b1; opcode = opc; operand_a = a; operand_b = b; write_pointer = wp;
        step();
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load_en = 1'b0; opcode = '0; operand_a = '0; operand_b = '0;
        write_pointer = '0; read_pointer = '0;
        step(); step();
        checks++;
        if (instruction_word !== '0 || rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            done_addr !== '0 || load_err !== 1'b0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got iw=%h v=%b busy=%b done=%b da=%0d le=%b dz=%b want all 0",
                     instruction_word, rd_valid, busy, done, done_addr, load_err, div_by_zero);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        logic [131:0] exp_iw;
        exp_iw = {4'd3, 32'd5, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE};
        do_load(4'd3, 32'd5, 32'hFFFF_FFF9, 5'd3);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL add_edgeN: got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        step();
        checks++;
        if (done !== 1'b1 || done_addr !== 5'd3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL add_done: got done=%b da=%0d busy=%b want done=1 da=3 busy=0", done, done_addr, busy);
        end
        read_pointer = 5'd3;
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++; $display("FAIL add_done_pulse: got done=%b want 0", done);
        end
        checks++;
        if (instruction_word !== exp_iw || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL add_read: got %h v=%b want %h v=1", instruction_word, rd_valid, exp_iw);
        end
    endtask

    // DIV/MOD of -17 by 5; a competing load at cycle 5 must be rejected
    task automatic test_div(input logic [3:0] opc, input logic [4:0] wp, input logic [63:0] exp_res);
        logic [131:0] exp_iw;
        int cyc;
        exp_iw = {opc, 32'hFFFF_FFEF, 32'd5, exp_res};
        read_pointer = wp;
        do_load(opc, 32'hFFFF_FFEF, 32'd5, wp);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            if (cyc == 5) begin
                load_en = 1'b1; opcode = 4'd3; operand_a = 32'd100; operand_b = 32'd100; write_pointer = wp;
            end
            step();
            cyc++;
            load_en = 1'b0;
            if (cyc == 3) begin
                checks++;
                if (rd_valid !== 1'b0) begin
                    failures++; $display("FAIL div_pending_valid: got %b want 0", rd_valid);
                end
            end
            if (cyc == 6) begin
                checks++;
                if (load_err !== 1'b1) begin
                    failures++; $display("FAIL div_load_err: got %b want 1", load_err);
                end
            end
            if (cyc == 7) begin
                checks++;
                if (load_err !== 1'b0) begin
                    failures++; $display("FAIL div_load_err_pulse: got %b want 0", load_err);
                end
            end
        end
        checks++;
        if (cyc !== 33 || done !== 1'b1 || done_addr !== wp || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL div_latency: got cycles=%0d done=%b da=%0d dz=%b want 33 1 %0d 0",
                     cyc, done, done_addr, div_by_zero, wp);
        end
        step();
        checks++;
        if (instruction_word !== exp_iw || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL div_read op%0d: got %h v=%b want %h v=1", opc, instruction_word, rd_valid, exp_iw);
        end
    endtask

    task automatic test_div_zero_and_mult();
        logic [131:0] exp_iw;
        exp_iw = {4'd6, 32'd9, 32'd0, 64'd0};
        read_pointer = 5'd4;
        do_load(4'd6, 32'd9, 32'd0, 5'd4);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL dz_edgeN: got busy=%b done=%b want 1 0", busy, done);
        end
        step();
        checks++;
        if (done !== 1'b1 || div_by_zero !== 1'b1 || done_addr !== 5'd4 || busy !== 1'b0) begin
            failures++;
            $display("FAIL dz_done: got done=%b dz=%b da=%0d busy=%b want 1 1 4 0", done, div_by_zero, done_addr, busy);
        end
        step();
        checks++;
        if (div_by_zero !== 1'b0 || instruction_word !== exp_iw || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL dz_read: got dz=%b %h v=%b want dz=0 %h v=1", div_by_zero, instruction_word, rd_valid, exp_iw);
        end
        exp_iw = {4'd5, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        read_pointer = 5'd5;
        do_load(4'd5, 32'h8000_0000, 32'h8000_0000, 5'd5);
        step();
        checks++;
        if (done !== 1'b1 || done_addr !== 5'd5) begin
            failures++; $display("FAIL mult_done: got done=%b da=%0d want 1 5", done, done_addr);
        end
        step();
        checks++;
        if (instruction_word !== exp_iw || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL mult_read: got %h v=%b want %h v=1", instruction_word, rd_valid, exp_iw);
        end
    endtask

    task automatic test_same_cycle();
        logic [131:0] old_iw, new_iw, fin_iw;
        old_iw = {4'd1, 32'd11, 32'd22, 64'd11};
        new_iw = {4'd4, 32'd10, 32'd3, 64'd0};
        fin_iw = {4'd4, 32'd10, 32'd3, 64'd7};
        do_load(4'd1, 32'd11, 32'd22, 5'd7);
        step();
        read_pointer = 5'd7;
        do_load(4'd4, 32'd10, 32'd3, 5'd7);
        checks++;
        if (instruction_word !== old_iw || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_old: got %h v=%b want %h v=1", instruction_word, rd_valid, old_iw);
        end
        step();
        checks++;
        if (instruction_word !== new_iw || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_wb_old: got %h v=%b want %h v=0", instruction_word, rd_valid, new_iw);
        end
        step();
        checks++;
        if (instruction_word !== fin_iw || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_new: got %h v=%b want %h v=1", instruction_word, rd_valid, fin_iw);
        end
    endtask

    task automatic test_reset_during_div();
        int done_cnt;
        do_load(4'd6, 32'd100, 32'd7, 5'd9);
        for (int i = 0; i < 10; i++) step();
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || instruction_word !== '0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_div: got busy=%b done=%b iw=%h v=%b want all 0", busy, done, instruction_word, rd_valid);
        end
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done === 1'b1) done_cnt++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_no_done: got done pulses=%0d busy=%b want 0 0", done_cnt, busy);
        end
        for (int i = 0; i < 32; i++) begin
            read_pointer = 5'(i);
            step();
            checks++;
            if (instruction_word !== '0 || rd_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_entry_%0d: got %h v=%b want 0 v=0", i, instruction_word, rd_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_div(4'd6, 5'd1, 64'hFFFF_FFFF_FFFF_FFFD);
        step();
        test_div(4'd7, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        test_div_zero_and_mult();
        test_same_cycle();
        test_reset_during_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
